// File: rtl/rr_stage.sv
// rr_stage: register-read stage between the issue queue and execute.
//
// Accepts one issued micro-op per cycle, reads both sources from the PRF,
// overrides them with the execute/writeback bypass buses, and holds the op in a
// single pipeline register that feeds execute. The held op stalls on the
// per-FU ready bit selected by its fu_sel and is squashed on mispredict when
// its ROB entry is set in flush_mask.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   IS_*  / IS_ready              issued micro-op in, accept handshake out
//   prf_rs*_idx / prf_rs*_data    PRF read address out, same-cycle data in
//   EX_out_* / WB_out_*           result bypass buses
//   EX_ready[7:0]                 per-FU ready from execute
//   mispredict, flush_mask        wrong-path squash
//   RR_valid, EXE_in_*            registered op presented to execute
//   stall_cnt                     saturating count of stalled cycles
//
// Configuration macro:
//   RR_WB_BYPASS_EN  defined   -> WB_out bypass participates in operand select
//                    undefined -> WB_out_* ignored; PRF must be write-through
module rr_stage #(
    parameter int ROB_LEN = 8,
    parameter int PREG_W  = 7,
    localparam int RI     = $clog2(ROB_LEN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              IS_valid,
    output logic              IS_ready,
    input  logic [2:0]        IS_fu_sel,
    input  logic [31:0]       IS_inst,
    input  logic [PREG_W-1:0] IS_rs1,
    input  logic [PREG_W-1:0] IS_rs2,
    input  logic [PREG_W-1:0] IS_rd,
    input  logic [31:0]       IS_imm,
    input  logic [31:0]       IS_pc,
    input  logic [4:0]        IS_op,
    input  logic [2:0]        IS_f3,
    input  logic [6:0]        IS_f7,
    input  logic [RI-1:0]     IS_rob_idx,
    input  logic              IS_jump,
    output logic [PREG_W-1:0] prf_rs1_idx,
    output logic [PREG_W-1:0] prf_rs2_idx,
    input  logic [31:0]       prf_rs1_data,
    input  logic [31:0]       prf_rs2_data,
    input  logic              EX_out_valid,
    input  logic [PREG_W-1:0] EX_out_rd,
    input  logic [31:0]       EX_out_data,
    input  logic              WB_out_valid,
    input  logic [PREG_W-1:0] WB_out_rd,
    input  logic [31:0]       WB_out_data,
    input  logic [7:0]        EX_ready,
    input  logic              mispredict,
    input  logic [ROB_LEN-1:0] flush_mask,
    output logic              RR_valid,
    output logic [2:0]        EXE_in_fu_sel,
    output logic [31:0]       EXE_in_inst,
    output logic [31:0]       EXE_in_rs1_data,
    output logic [31:0]       EXE_in_rs2_data,
    output logic [31:0]       EXE_in_imm,
    output logic [31:0]       EXE_in_pc,
    output logic [PREG_W-1:0] EXE_in_rd,
    output logic [4:0]        EXE_in_op,
    output logic [2:0]        EXE_in_f3,
    output logic [6:0]        EXE_in_f7,
    output logic [RI-1:0]     EXE_in_rob_idx,
    output logic              EXE_in_jump,
    output logic [31:0]       stall_cnt
);

    // Operand select: tag 0 is the zero register; EX bypass beats WB bypass
    // because it carries the younger result for the same tag.
    function automatic logic [31:0] sel_operand(input logic [PREG_W-1:0] tag,
                                                input logic [31:0]       prf);
        if (tag == '0)
            return 32'd0;
        if (EX_out_valid && (EX_out_rd == tag))
            return EX_out_data;
`ifdef RR_WB_BYPASS_EN
        if (WB_out_valid && (WB_out_rd == tag))
            return WB_out_data;
`endif
        return prf;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

`ifndef RR_WB_BYPASS_EN
    logic unused_wb;
    assign unused_wb = ^{WB_out_valid, WB_out_rd, WB_out_data};
`endif

    logic vld_p1;
    logic fire;
    logic stall_blk;
    logic accept;
    logic in_squash;
    logic held_squash;
    logic [31:0] rs1_data_p0;
    logic [31:0] rs2_data_p0;

    // Stage p0: combinational handshake, squash decode and operand read.
    assign stall_blk   = 1'b0;  // reserved back-pressure hook, tied off
    assign fire        = vld_p1 && EX_ready[EXE_in_fu_sel];
    assign IS_ready    = (!vld_p1 || fire) && !stall_blk;
    assign accept      = IS_valid && IS_ready;
    // A squashed incoming op is still consumed (IS_ready stays 1) but never loaded.
    assign in_squash   = mispredict && flush_mask[IS_rob_idx];
    assign held_squash = mispredict && flush_mask[EXE_in_rob_idx];

    assign prf_rs1_idx = IS_rs1;
    assign prf_rs2_idx = IS_rs2;
    assign rs1_data_p0 = sel_operand(IS_rs1, prf_rs1_data);
    assign rs2_data_p0 = sel_operand(IS_rs2, prf_rs2_data);

    // Stage p1: pipeline register presented to execute; operands frozen while held.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1          <= 1'b0;
            EXE_in_fu_sel   <= '0;
            EXE_in_inst     <= '0;
            EXE_in_rs1_data <= '0;
            EXE_in_rs2_data <= '0;
            EXE_in_imm      <= '0;
            EXE_in_pc       <= '0;
            EXE_in_rd       <= '0;
            EXE_in_op       <= '0;
            EXE_in_f3       <= '0;
            EXE_in_f7       <= '0;
            EXE_in_rob_idx  <= '0;
            EXE_in_jump     <= 1'b0;
            stall_cnt       <= '0;
        end else begin
            if (accept && !in_squash) begin
                vld_p1          <= 1'b1;
                EXE_in_fu_sel   <= IS_fu_sel;
                EXE_in_inst     <= IS_inst;
                EXE_in_rs1_data <= rs1_data_p0;
                EXE_in_rs2_data <= rs2_data_p0;
                EXE_in_imm      <= IS_imm;
                EXE_in_pc       <= IS_pc;
                EXE_in_rd       <= IS_rd;
                EXE_in_op       <= IS_op;
                EXE_in_f3       <= IS_f3;
                EXE_in_f7       <= IS_f7;
                EXE_in_rob_idx  <= IS_rob_idx;
                EXE_in_jump     <= IS_jump;
            end else if (fire || held_squash) begin
                vld_p1 <= 1'b0;
            end
            if (vld_p1 && !EX_ready[EXE_in_fu_sel])
                stall_cnt <= sat_inc(stall_cnt);
        end
    end

    assign RR_valid = vld_p1;

endmodule

// File: tb/tb_rr_stage.sv
module tb_rr_stage;

    logic        clk;
    logic        rst;
    logic        IS_valid;
    logic        IS_ready;
    logic [2:0]  IS_fu_sel;
    logic [31:0] IS_inst;
    logic [6:0]  IS_rs1;
    logic [6:0]  IS_rs2;
    logic [6:0]  IS_rd;
    logic [31:0] IS_imm;
    logic [31:0] IS_pc;
    logic [4:0]  IS_op;
    logic [2:0]  IS_f3;
    logic [6:0]  IS_f7;
    logic [2:0]  IS_rob_idx;
    logic        IS_jump;
    logic [6:0]  prf_rs1_idx;
    logic [6:0]  prf_rs2_idx;
    logic [31:0] prf_rs1_data;
    logic [31:0] prf_rs2_data;
    logic        EX_out_valid;
    logic [6:0]  EX_out_rd;
    logic [31:0] EX_out_data;
    logic        WB_out_valid;
    logic [6:0]  WB_out_rd;
    logic [31:0] WB_out_data;
    logic [7:0]  EX_ready;
    logic        mispredict;
    logic [7:0]  flush_mask;
    logic        RR_valid;
    logic [2:0]  EXE_in_fu_sel;
    logic [31:0] EXE_in_inst;
    logic [31:0] EXE_in_rs1_data;
    logic [31:0] EXE_in_rs2_data;
    logic [31:0] EXE_in_imm;
    logic [31:0] EXE_in_pc;
    logic [6:0]  EXE_in_rd;
    logic [4:0]  EXE_in_op;
    logic [2:0]  EXE_in_f3;
    logic [6:0]  EXE_in_f7;
    logic [2:0]  EXE_in_rob_idx;
    logic        EXE_in_jump;
    logic [31:0] stall_cnt;

    int total;
    int bad;

    rr_stage #(.ROB_LEN(8), .PREG_W(7)) dut (
        .clk(clk), .rst(rst),
        .IS_valid(IS_valid), .IS_ready(IS_ready), .IS_fu_sel(IS_fu_sel),
        .IS_inst(IS_inst), .IS_rs1(IS_rs1), .IS_rs2(IS_rs2), .IS_rd(IS_rd),
        .IS_imm(IS_imm), .IS_pc(IS_pc), .IS_op(IS_op), .IS_f3(IS_f3),
        .IS_f7(IS_f7), .IS_rob_idx(IS_rob_idx), .IS_jump(IS_jump),
        .prf_rs1_idx(prf_rs1_idx), .prf_rs2_idx(prf_rs2_idx),
        .prf_rs1_data(prf_rs1_data), .prf_rs2_data(prf_rs2_data),
        .EX_out_valid(EX_out_valid), .EX_out_rd(EX_out_rd), .EX_out_data(EX_out_data),
        .WB_out_valid(WB_out_valid), .WB_out_rd(WB_out_rd), .WB_out_data(WB_out_data),
        .EX_ready(EX_ready), .mispredict(mispredict), .flush_mask(flush_mask),
        .RR_valid(RR_valid), .EXE_in_fu_sel(EXE_in_fu_sel), .EXE_in_inst(EXE_in_inst),
        .EXE_in_rs1_data(EXE_in_rs1_data), .EXE_in_rs2_data(EXE_in_rs2_data),
        .EXE_in_imm(EXE_in_imm), .EXE_in_pc(EXE_in_pc), .EXE_in_rd(EXE_in_rd),
        .EXE_in_op(EXE_in_op), .EXE_in_f3(EXE_in_f3), .EXE_in_f7(EXE_in_f7),
        .EXE_in_rob_idx(EXE_in_rob_idx), .EXE_in_jump(EXE_in_jump),
        .stall_cnt(stall_cnt)
    );

    // PRF model: register 5 holds 0x11, every other register holds 0x100 + tag.
    assign prf_rs1_data = (prf_rs1_idx == 7'd5) ? 32'h11 : 32'h100 + 32'(prf_rs1_idx);
    assign prf_rs2_data = (prf_rs2_idx == 7'd5) ? 32'h11 : 32'h100 + 32'(prf_rs2_idx);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic set_op(input logic [2:0] fu, input logic [6:0] rs1, input logic [6:0] rs2,
                          input logic [2:0] rob, input logic [31:0] pc);
        IS_fu_sel  = fu;
        IS_rs1     = rs1;
        IS_rs2     = rs2;
        IS_rob_idx = rob;
        IS_pc      = pc;
        IS_inst    = pc ^ 32'h0000_0013;
        IS_rd      = rs1 + 7'd1;
        IS_imm     = pc + 32'd8;
        IS_op      = 5'h04;
        IS_f3      = 3'd0;
        IS_f7      = 7'd0;
        IS_jump    = 1'b0;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b1;
        IS_valid = 1'b0;
        set_op(3'd0, 7'd0, 7'd0, 3'd0, 32'd0);
        EX_out_valid = 1'b0; EX_out_rd = '0; EX_out_data = '0;
        WB_out_valid = 1'b0; WB_out_rd = '0; WB_out_data = '0;
        EX_ready = 8'hFF;
        mispredict = 1'b0;
        flush_mask = 8'h00;

        step();
        step();
        chk("rst_valid", 32'(RR_valid), 32'd0);
        chk("rst_stall", stall_cnt, 32'd0);
        chk("rst_pc", EXE_in_pc, 32'd0);
        rst = 1'b0;

        // Basic ALU op: rs1 from PRF, rs2 is x0.
        set_op(3'd0, 7'd5, 7'd0, 3'd1, 32'h100);
        IS_valid = 1'b1;
        #1;
        chk("idle_ready", 32'(IS_ready), 32'd1);
        chk("prf_idx", 32'(prf_rs1_idx), 32'd5);
        step();
        chk("alu_valid", 32'(RR_valid), 32'd1);
        chk("alu_rs1", EXE_in_rs1_data, 32'h11);
        chk("alu_rs2", EXE_in_rs2_data, 32'd0);
        chk("alu_pc", EXE_in_pc, 32'h100);
        chk("alu_imm", EXE_in_imm, 32'h108);

        // EX bypass wins over WB bypass.
        set_op(3'd0, 7'd9, 7'd9, 3'd2, 32'h104);
        EX_out_valid = 1'b1; EX_out_rd = 7'd9; EX_out_data = 32'hAAAA;
        WB_out_valid = 1'b1; WB_out_rd = 7'd9; WB_out_data = 32'hBBBB;
        step();
        chk("ex_byp_rs1", EXE_in_rs1_data, 32'hAAAA);
        chk("ex_byp_rs2", EXE_in_rs2_data, 32'hAAAA);

        // WB bypass only (PRF value when the WB bypass is compiled out).
        set_op(3'd0, 7'd9, 7'd6, 3'd3, 32'h108);
        EX_out_valid = 1'b0;
        step();
`ifdef RR_WB_BYPASS_EN
        chk("wb_byp_rs1", EXE_in_rs1_data, 32'hBBBB);
`else
        chk("wb_byp_rs1", EXE_in_rs1_data, 32'h109);
`endif
        chk("wb_byp_rs2", EXE_in_rs2_data, 32'h106);
        WB_out_valid = 1'b0;

        // Tag 0 ignores a bypass that targets tag 0.
        set_op(3'd0, 7'd0, 7'd6, 3'd4, 32'h10C);
        EX_out_valid = 1'b1; EX_out_rd = 7'd0; EX_out_data = 32'hDEAD;
        step();
        chk("x0_rs1", EXE_in_rs1_data, 32'd0);
        chk("x0_rs2", EXE_in_rs2_data, 32'h106);
        EX_out_valid = 1'b0;

        // DIV stall for three cycles with a waiting issued op.
        set_op(3'd2, 7'd3, 7'd4, 3'd4, 32'h200);
        EX_ready = 8'hFB;
        step();
        chk("div_valid", 32'(RR_valid), 32'd1);
        set_op(3'd0, 7'd7, 7'd0, 3'd5, 32'h300);
        for (int i = 0; i < 3; i++) begin
            chk("div_block", 32'(IS_ready), 32'd0);
            step();
            chk("div_hold_pc", EXE_in_pc, 32'h200);
        end
        chk("div_stall", stall_cnt, 32'd3);
        chk("div_rs1_frz", EXE_in_rs1_data, 32'h103);
        EX_ready = 8'hFF;
        #1;
        chk("div_release", 32'(IS_ready), 32'd1);
        step();
        chk("b2b_valid", 32'(RR_valid), 32'd1);
        chk("b2b_pc", EXE_in_pc, 32'h300);
        chk("b2b_rs1", EXE_in_rs1_data, 32'h107);
        chk("b2b_stall", stall_cnt, 32'd3);

        // Held stalled op squashed by mispredict.
        set_op(3'd2, 7'd1, 7'd2, 3'd4, 32'h400);
        EX_ready = 8'hFB;
        step();
        chk("sq_load_pc", EXE_in_pc, 32'h400);
        IS_valid = 1'b0;
        mispredict = 1'b1; flush_mask = 8'h30;
        step();
        mispredict = 1'b0; flush_mask = 8'h00;
        chk("sq_held_valid", 32'(RR_valid), 32'd0);
        chk("sq_held_pc", EXE_in_pc, 32'h400);
        chk("sq_held_stall", stall_cnt, 32'd4);

        // Held op squashed while a surviving op is accepted the same cycle.
        EX_ready = 8'hFF;
        set_op(3'd0, 7'd1, 7'd2, 3'd4, 32'h500);
        IS_valid = 1'b1;
        step();
        set_op(3'd0, 7'd3, 7'd0, 3'd2, 32'h600);
        mispredict = 1'b1; flush_mask = 8'h30;
        #1;
        chk("sq_swap_ready", 32'(IS_ready), 32'd1);
        step();
        chk("sq_swap_valid", 32'(RR_valid), 32'd1);
        chk("sq_swap_pc", EXE_in_pc, 32'h600);

        // Incoming op squashed: consumed but not loaded.
        set_op(3'd0, 7'd8, 7'd0, 3'd5, 32'h700);
        flush_mask = 8'h20;
        #1;
        chk("sq_in_ready", 32'(IS_ready), 32'd1);
        step();
        mispredict = 1'b0; flush_mask = 8'h00;
        IS_valid = 1'b0;
        chk("sq_in_valid", 32'(RR_valid), 32'd0);
        chk("sq_in_pc", EXE_in_pc, 32'h600);

        // Continuous ALU stream, one op per cycle, in order.
        IS_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            set_op(3'd0, 7'(10 + i), 7'd0, 3'(i), 32'h1000 + 32'(4 * i));
            step();
            chk("strm_valid", 32'(RR_valid), 32'd1);
            chk("strm_pc", EXE_in_pc, 32'h1000 + 32'(4 * i));
            chk("strm_rs1", EXE_in_rs1_data, 32'h10A + 32'(i));
        end
        IS_valid = 1'b0;
        chk("strm_stall", stall_cnt, 32'd4);
        step();
        chk("strm_drain", 32'(RR_valid), 32'd0);

        // Store gated by EX_ready[7], then reset mid-stall.
        set_op(3'd7, 7'd2, 7'd3, 3'd6, 32'h800);
        EX_ready = 8'h7F;
        IS_valid = 1'b1;
        step();
        chk("st_valid", 32'(RR_valid), 32'd1);
        chk("st_block", 32'(IS_ready), 32'd0);
        step();
        chk("st_hold", 32'(RR_valid), 32'd1);
        chk("st_stall", stall_cnt, 32'd5);
        IS_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_mid_valid", 32'(RR_valid), 32'd0);
        chk("rst_mid_stall", stall_cnt, 32'd0);
        chk("rst_mid_pc", EXE_in_pc, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
